regfile_wb_arbiter: RTL

- Shares the register file's single write port between two writeback requesters.
- Requester A is the pipeline writeback stage and has priority. Requester B is the I/O / sensor-load path.
- The block registers the winning request and drives wr_addr[4:0] into the 5-to-32 write-enable decoder, plus wr_data and wr_en.
- A starvation counter forces a grant to B after a bounded wait, stalling A for that cycle.

---
 rtl/regfile_wb_arbiter_if.sv | 24 ++
 rtl/regfile_wb_arbiter.sv | 67 ++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requester handshakes and the registered register-file write port.
interface regfile_wb_arbiter_if #(parameter int DATA_W = 32);
   logic              a_valid;
   logic [4:0]        a_addr;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;
   logic              b_valid;
   logic [4:0]        b_addr;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;
   logic              wr_en;
   logic [4:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_src;
   logic              forcing;
   modport master (
      output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      input  a_ready, b_ready, wr_en, wr_addr, wr_data, wr_src, forcing
   );
   modport slave (
      input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      output a_ready, b_ready, wr_en, wr_addr, wr_data, wr_src, forcing
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between priority writeback A and I/O path B,
// forcing a B grant after STARVE_LIMIT consecutive refusals.
module regfile_wb_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int DATA_W       = 32
) (
   input logic                 clock,
   input logic                 reset,
   regfile_wb_arbiter_if.slave bus
);
   typedef enum logic {NORMAL, FORCE_B} state_t;
   state_t            r_state;
   logic [7:0]        r_starve_cnt;
   logic              r_wr_en;
   logic [4:0]        r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic              r_wr_src;
   logic              w_a_ready;
   logic              w_b_ready;
   logic              w_grant_a;
   logic              w_grant_b;
   logic              w_refused;
   // Readies depend only on state and a_valid, never on the registered write port.
   always_comb begin
      w_a_ready = !reset && (r_state == NORMAL);
      w_b_ready = !reset && ((r_state == FORCE_B) || !bus.a_valid);
      w_grant_a = bus.a_valid && w_a_ready;
      w_grant_b = bus.b_valid && w_b_ready;
      w_refused = bus.b_valid && !w_b_ready;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= NORMAL;
         r_starve_cnt <= 8'd0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= 5'd0;
         r_wr_data    <= '0;
         r_wr_src     <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         if (w_grant_a) begin
            r_wr_en   <= bus.a_addr != 5'd0;
            r_wr_addr <= bus.a_addr;
            r_wr_data <= bus.a_data;
            r_wr_src  <= 1'b0;
         end else if (w_grant_b) begin
            r_wr_en   <= bus.b_addr != 5'd0;
            r_wr_addr <= bus.b_addr;
            r_wr_data <= bus.b_data;
            r_wr_src  <= 1'b1;
         end
         r_starve_cnt <= (!bus.b_valid || w_grant_b) ? 8'd0 :
                         (r_starve_cnt != 8'hFF) ? r_starve_cnt + 8'd1 : r_starve_cnt;
         if (r_state == NORMAL)
            r_state <= (w_refused && r_starve_cnt == 8'(STARVE_LIMIT - 1)) ? FORCE_B : NORMAL;
         else
            r_state <= (w_grant_b || !bus.b_valid) ? NORMAL : FORCE_B;
      end
   end
   assign bus.a_ready = w_a_ready;
   assign bus.b_ready = w_b_ready;
   assign bus.wr_en   = r_wr_en;
   assign bus.wr_addr = r_wr_addr;
   assign bus.wr_data = r_wr_data;
   assign bus.wr_src  = r_wr_src;
   assign bus.forcing = r_state == FORCE_B;
endmodule
